matrix_writeback: RTL
=====================

Name: matrix_writeback

Overview:
- Write-side counterpart of the register file's matrix read ports.
- Accepts a packed result matrix from the FC/conv datapath over a valid/ready handshake.
- Serialises the matrix into one register-file write per cycle, driving the register file's RegWrite/RDaddr/RDdata/is_pos inputs with per-byte sign flags.
- Sits between the accelerator output and the register-file write port. The core pipeline has priority on that port through a stall input.

Parameters:
- FC_BITWIDTH, 8, bits per matrix element.
- OUT_SIZE, 4, elements per row and rows per matrix. FC_BITWIDTH*OUT_SIZE must equal 32; OUT_SIZE must equal 4.
- FILE_SIZE, 16, register-file depth. Destination addresses wrap modulo FILE_SIZE.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- res_valid_i  input  1  result matrix valid.
- res_ready_o  output  1  block can accept a matrix.
- res_matrix_i  input  FC_BITWIDTH*OUT_SIZE*OUT_SIZE  packed result. Row r = bits [32*(r+1)-1 -: 32]; byte k of a row = bits [8k+7:8k].
- dest_base_i  input  5  register address for row 0.
- row_count_i  input  3  rows to write, 1..OUT_SIZE; 0 means OUT_SIZE.
- stall_i  input  1  core owns the write port this cycle.
- RegWrite_o  output  1  register-file write enable.
- RDaddr_o  output  5  write address.
- RDdata_o  output  32  write data.
- is_pos_o  output  4  bit k = ~RDdata_o[8k+7].
- busy_o  output  1  high while not IDLE.
- done_o  output  1  one-cycle pulse after the final write.

Behaviour:
- States: IDLE, WRITE, DONE. Encoding is free.
- Reset (synchronous, active-high): state=IDLE, row index=0, captured matrix/base/count=0.
  - Outputs after reset: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, is_pos_o=0, busy_o=0, done_o=0, res_ready_o=1.
  - Reset asserted mid-transfer aborts it. No further writes occur and no done_o is produced.
- IDLE:
  - res_ready_o=1, RegWrite_o=0.
  - On an edge with res_valid_i=1, capture res_matrix_i, dest_base_i and the effective count (0 becomes 4). Clear the row index and go to WRITE.
- WRITE:
  - res_ready_o=0, busy_o=1.
  - RegWrite_o = ~stall_i (combinational from state and stall_i).
  - RDaddr_o = (base + idx) mod FILE_SIZE, zero-extended to 5 bits.
  - RDdata_o = captured row idx; is_pos_o derived from RDdata_o.
  - On an edge with stall_i=0:
    - if idx == count-1, go to DONE;
    - otherwise idx increments.
  - On an edge with stall_i=1, nothing changes, and RDaddr_o/RDdata_o hold their values.
- DONE:
  - done_o=1, RegWrite_o=0, busy_o=1, res_ready_o=0.
  - Unconditionally return to IDLE on the next edge.
- Latency, with the handshake accepted at edge N and no stalls:
  - row r is presented in the cycle after edge N+r and committed by the register file's negedge write;
  - done_o is high in the cycle after edge N+count;
  - res_ready_o returns high the cycle after that.
  - Each stall cycle adds exactly one cycle.
- When RegWrite_o=0, RDaddr_o/RDdata_o/is_pos_o are don't-care for function but must be stable (no X). Drive them from the captured row 0 / index.
- res_matrix_i and dest_base_i changing after acceptance have no effect.
- No second matrix is accepted until IDLE; there is no buffering beyond one matrix.
- Address wrap: base 14 with count 4 writes addresses 14, 15, 0, 1.
- Element values are passed through unmodified. is_pos treats 0x00 as positive (sign bit clear).

Test Plan:
- Basic transfer:
  - Stimulus: reset, then valid with matrix rows {0x01010101, 0x02020202, 0x03030303, 0x04040404} (row0 first), base 5, count 0, stall 0.
  - Required: writes to 5, 6, 7, 8 on four consecutive cycles with those data and is_pos=4'hF; done_o pulses once; ready returns high 1 cycle after the pulse.
- Sign flags:
  - Stimulus: row0 = 0x80_7F_FF_00, count 1, base 9.
  - Required: one write addr 9, data 0x807F_FF00, is_pos=4'b0101, done_o the next cycle.
- Stalls:
  - Stimulus: count 4, base 12, stall_i held high for 2 cycles during row 1.
  - Required: RegWrite_o low those 2 cycles with addr 13 held; rows written to 12, 13, 14, 15 with no skip or duplicate; done_o 2 cycles later than the unstalled case.
- Wrap and partial count:
  - Stimulus: base 14, count 3.
  - Required: writes to 14, 15, 0 only.
- Handshake and reset:
  - Stimulus: hold res_valid_i high with a different matrix during an ongoing transfer.
  - Required: ignored, res_ready_o=0, second matrix accepted only in IDLE.
  - Stimulus: assert reset after row 1 is written.
  - Required: no further RegWrite_o, no done_o, ready=1 and all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/matrix_writeback.sv
// Serialises a packed result matrix into one register-file write per cycle.
// The core pipeline keeps priority on the write port through stall_i.
module matrix_writeback #(
   parameter int FC_BITWIDTH = 8,
   parameter int OUT_SIZE    = 4,
   parameter int FILE_SIZE   = 16
) (
   input  logic                                   clk_i,
   input  logic                                   reset,
   input  logic                                   res_valid_i,
   output logic                                   res_ready_o,
   input  logic [FC_BITWIDTH*OUT_SIZE*OUT_SIZE-1:0] res_matrix_i,
   input  logic [4:0]                             dest_base_i,
   input  logic [2:0]                             row_count_i,
   input  logic                                   stall_i,
   output logic                                   RegWrite_o,
   output logic [4:0]                             RDaddr_o,
   output logic [FC_BITWIDTH*OUT_SIZE-1:0]        RDdata_o,
   output logic [OUT_SIZE-1:0]                    is_pos_o,
   output logic                                   busy_o,
   output logic                                   done_o
);

   localparam int ROW_W = FC_BITWIDTH * OUT_SIZE;
   localparam int MAT_W = ROW_W * OUT_SIZE;
   localparam int IDX_W = $clog2(OUT_SIZE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [MAT_W-1:0]   matrix_reg, matrix_next;
   logic [4:0]         base_reg, base_next;
   logic [2:0]         count_reg, count_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;

   logic [2:0]         count_eff;
   logic               last_row;
   logic [IDX_W-1:0]   rd_idx;
   logic [5:0]         addr_sum;
   logic [5:0]         addr_mod;
   logic               in_write;
   logic [ROW_W-1:0]   rows [OUT_SIZE];

   genvar gi;

   generate
      for (gi = 0; gi < OUT_SIZE; gi = gi + 1) begin : g_rows
         assign rows[gi] = matrix_reg[ROW_W*(gi+1)-1 -: ROW_W];
      end
   endgenerate

   // A count of 0 means a full matrix; out-of-range counts are clamped so the
   // row index can never run past the last captured row.
   always_comb begin
      count_eff = row_count_i;
      if (row_count_i == 3'd0 || row_count_i > 3'(OUT_SIZE)) begin
         count_eff = 3'(OUT_SIZE);
      end
   end

   assign last_row = (3'(idx_reg) == (count_reg - 3'd1));

   // State and captured-matrix registers
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         matrix_reg <= '0;
         base_reg   <= '0;
         count_reg  <= '0;
         idx_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         matrix_reg <= matrix_next;
         base_reg   <= base_next;
         count_reg  <= count_next;
         idx_reg    <= idx_next;
      end
   end

   // Next-state and capture logic
   always_comb begin
      state_next  = state_reg;
      matrix_next = matrix_reg;
      base_next   = base_reg;
      count_next  = count_reg;
      idx_next    = idx_reg;
      case (state_reg)
         ST_IDLE: begin
            if (res_valid_i) begin
               matrix_next = res_matrix_i;
               base_next   = dest_base_i;
               count_next  = count_eff;
               idx_next    = '0;
               state_next  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (!stall_i) begin
               if (last_row) begin
                  state_next = ST_DONE;
               end else begin
                  idx_next = idx_reg + IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs; outside WRITE the bus shows row 0 at the base address so it never floats
   always_comb begin
      in_write    = (state_reg == ST_WRITE);
      res_ready_o = (state_reg == ST_IDLE);
      busy_o      = (state_reg != ST_IDLE);
      done_o      = (state_reg == ST_DONE);
      RegWrite_o  = in_write && !stall_i;
      rd_idx      = in_write ? idx_reg : '0;
      addr_sum    = 6'(base_reg) + 6'(rd_idx);
      addr_mod    = addr_sum % 6'(FILE_SIZE);
      RDaddr_o    = addr_mod[4:0];
      RDdata_o    = rows[rd_idx];
   end

   // Sign flags are only meaningful during WRITE; elsewhere they read as zero
   generate
      for (gi = 0; gi < OUT_SIZE; gi = gi + 1) begin : g_pos
         assign is_pos_o[gi] = in_write & ~RDdata_o[FC_BITWIDTH*(gi+1)-1];
      end
   endgenerate

endmodule
